mips_mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control unit; successor to the single-cycle decoder/top pairing.
//  FSM sequences each instruction over 3-5 cycles: fetch, decode, execute, memory, writeback.

---
 rtl/mips_mc_ctrl.sv | 274 +++++++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_mc_ctrl
// Purpose  : Multi-cycle MIPS control unit. Sequences each instruction through
//            fetch / decode / execute / memory / writeback over 3-5 cycles and
//            drives the datapath muxes, enables and ALU operation. Instruction
//            and data accesses share one memory port through a req/ready
//            handshake with a bounded wait. Unsupported instructions and
//            memory timeouts park the FSM in HALT with a sticky flag.
// Ports    : clk, reset (async, active-low)
//            opcode/funct/zf      <- datapath (IR fields, ALU zero flag)
//            mem_ready            <- memory completes request this cycle
//            mem_req/mem_we/iord  -> memory port control
//            ir_we/pc_we/pc_src   -> IR and PC update control
//            alu_src_a/alu_src_b/alu_ctr/ext_op -> ALU operand/op select
//            reg_dst/reg_we/mem_to_reg          -> register file write path
//            state/illegal/timeout/cycles/instret -> status and counters
// Revision : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zf,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctr,
  output logic             ext_op,
  output logic             reg_dst,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I  = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_R    = 4'd7,
    S_WB_I   = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP    = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_ADDIU = 6'b001001;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  localparam logic [5:0] c_FN_ADDU  = 6'b100001;
  localparam logic [5:0] c_FN_SUBU  = 6'b100011;
  localparam logic [5:0] c_FN_AND   = 6'b100100;
  localparam logic [5:0] c_FN_OR    = 6'b100101;
  localparam logic [5:0] c_FN_SLT   = 6'b101010;

  localparam logic [2:0] c_ALU_ADD  = 3'b000;
  localparam logic [2:0] c_ALU_SUB  = 3'b001;
  localparam logic [2:0] c_ALU_AND  = 3'b010;
  localparam logic [2:0] c_ALU_OR   = 3'b011;
  localparam logic [2:0] c_ALU_SLT  = 3'b100;

  // The wait counter only has to reach MEM_TIMEOUT-1: the limit is hit on the
  // cycle whose stall would make the count equal MEM_TIMEOUT.
  localparam int                  c_WAIT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next;
  state_t              w_dec_next;
  logic [c_WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]    r_cycles;
  logic [CNT_W-1:0]    r_instret;
  logic                r_illegal;
  logic                r_timeout;

  logic       w_mem_phase, w_wait_expired, w_retire, w_funct_ok;
  logic [2:0] w_r_alu;
  logic       w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we;
  logic [1:0] w_pc_src, w_alu_src_b;
  logic       w_alu_src_a, w_ext_op, w_reg_dst, w_reg_we, w_mem_to_reg;
  logic [2:0] w_alu_ctr;

  // R-type funct decode: legality and ALU operation
  always_comb begin
    w_funct_ok = 1'b1;
    w_r_alu    = c_ALU_ADD;
    case (funct)
      c_FN_ADDU: w_r_alu = c_ALU_ADD;
      c_FN_SUBU: w_r_alu = c_ALU_SUB;
      c_FN_AND:  w_r_alu = c_ALU_AND;
      c_FN_OR:   w_r_alu = c_ALU_OR;
      c_FN_SLT:  w_r_alu = c_ALU_SLT;
      default:   w_funct_ok = 1'b0;
    endcase
  end

  // Dispatch out of DECODE; anything unrecognised traps to HALT
  always_comb begin
    w_dec_next = S_HALT;
    case (opcode)
      c_OP_RTYPE: if (w_funct_ok) w_dec_next = S_EXEC_R;
      c_OP_ADDIU,
      c_OP_ORI:   w_dec_next = S_EXEC_I;
      c_OP_LW,
      c_OP_SW:    w_dec_next = S_ADDR;
      c_OP_BEQ:   w_dec_next = S_BRANCH;
      c_OP_J:     w_dec_next = S_JUMP;
      default:    w_dec_next = S_HALT;
    endcase
  end

  assign w_mem_phase    = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // A ready on the limit cycle still completes the transfer
  assign w_wait_expired = (MEM_TIMEOUT != 0) && w_mem_phase && !mem_ready && (r_wait == c_WAIT_LAST);
  assign w_retire       = (r_state == S_WB_R) || (r_state == S_WB_I) || (r_state == S_WB_MEM) ||
                          (r_state == S_BRANCH) || (r_state == S_JUMP) ||
                          ((r_state == S_MEM_WR) && mem_ready);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE; else if (w_wait_expired) w_next = S_HALT;
      S_DECODE: w_next = w_dec_next;
      S_EXEC_R: w_next = S_WB_R;
      S_EXEC_I: w_next = S_WB_I;
      S_ADDR:   w_next = (opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) w_next = S_WB_MEM; else if (w_wait_expired) w_next = S_HALT;
      S_MEM_WR: if (mem_ready) w_next = S_FETCH;  else if (w_wait_expired) w_next = S_HALT;
      S_WB_R,
      S_WB_I,
      S_WB_MEM,
      S_BRANCH,
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_cycles  <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait <= '0;
      else if (w_mem_phase && !mem_ready)
        r_wait <= r_wait + c_WAIT_W'(1);
      if (r_state != S_HALT)
        r_cycles <= r_cycles + CNT_W'(1);
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
      if ((r_state == S_DECODE) && (w_dec_next == S_HALT))
        r_illegal <= 1'b1;
      if (w_wait_expired)
        r_timeout <= 1'b1;
    end
  end

  // Moore decode of the state; FETCH enables and BRANCH pc_we also follow
  // mem_ready / zf of the current cycle.
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_iord       = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_alu_ctr    = c_ALU_ADD;
    w_ext_op     = 1'b0;
    w_reg_dst    = 1'b0;
    w_reg_we     = 1'b0;
    w_mem_to_reg = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_we     = mem_ready;
        w_pc_we     = mem_ready;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        w_ext_op    = 1'b1;
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_ctr   = w_r_alu;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        if (opcode == c_OP_ORI) w_alu_ctr = c_ALU_OR;
        else                    w_ext_op  = 1'b1;
      end
      S_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_ext_op    = 1'b1;
      end
      S_MEM_RD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        w_mem_we  = 1'b1;
      end
      S_WB_R: w_reg_we = 1'b1;
      S_WB_I: begin
        w_reg_we  = 1'b1;
        w_reg_dst = 1'b1;
      end
      S_WB_MEM: begin
        w_reg_we     = 1'b1;
        w_reg_dst    = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_ctr   = c_ALU_SUB;
        w_pc_src    = 2'b01;
        w_pc_we     = zf;
      end
      S_JUMP: begin
        w_pc_src = 2'b10;
        w_pc_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Gate with reset so a mid-instruction reset drops the request immediately
  assign mem_req    = reset & w_mem_req;
  assign mem_we     = reset & w_mem_we;
  assign iord       = reset & w_iord;
  assign ir_we      = reset & w_ir_we;
  assign pc_we      = reset & w_pc_we;
  assign pc_src     = reset ? w_pc_src    : 2'b00;
  assign alu_src_a  = reset & w_alu_src_a;
  assign alu_src_b  = reset ? w_alu_src_b : 2'b00;
  assign alu_ctr    = reset ? w_alu_ctr   : 3'b000;
  assign ext_op     = reset & w_ext_op;
  assign reg_dst    = reset & w_reg_dst;
  assign reg_we     = reset & w_reg_we;
  assign mem_to_reg = reset & w_mem_to_reg;
  assign state      = r_state;
  assign illegal    = r_illegal;
  assign timeout    = r_timeout;
  assign cycles     = r_cycles;
  assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_mc_ctrl
// Purpose  : Self-checking bench for mips_mc_ctrl. A driver feeds instructions
//            (IR model) and a memory model with per-phase wait counts; each
//            issued instruction pushes its expected state trace, latency and
//            control summary into a queue that a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_mc_ctrl;
  localparam int CNT_W = 32;
  localparam int TMO   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [5:0]       opcode = 6'd0, funct = 6'd0;
  logic             zf = 1'b0, mem_ready = 1'b0;
  logic             mem_req, mem_we, iord, ir_we, pc_we;
  logic [1:0]       pc_src, alu_src_b;
  logic             alu_src_a, ext_op, reg_dst, reg_we, mem_to_reg;
  logic [2:0]       alu_ctr;
  logic [3:0]       state;
  logic             illegal, timeout;
  logic [CNT_W-1:0] cycles, instret;

  mips_mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zf(zf),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctr(alu_ctr), .ext_op(ext_op), .reg_dst(reg_dst),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .state(state), .illegal(illegal),
    .timeout(timeout), .cycles(cycles), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] op; logic [5:0] fn; logic z; } instr_t;
  typedef struct { int trace; int lat; int alu; int regwe; int pcwe; int pcsrc; int memwe; int ext; } exp_t;

  instr_t prog_q[$];
  int     wait_q[$];
  exp_t   exp_q[$];

  int vectors = 0, miscompares = 0;
  // driver state
  int     cur_wait = -1;
  bit     load_ir = 0;
  instr_t ins;
  // monitor state
  bit mon_en = 0, have_rec = 0;
  int prev_st = 15;
  int rec_trace, rec_len, rec_alu, rec_ext, rec_regwe, rec_pcwe, rec_pcsrc, rec_memwe, rec_err;
  int n_ret = 0, sum_lat = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int push_st(input int t, input int s);
    return ((t << 4) | s) & 32'hFFFFFF;
  endfunction

  // Reference: each instruction class visits a fixed list of states; latency
  // is one cycle per state plus the memory stalls applied to it.
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    exp_t   e;
    instr_t p;
    int     nst;
    bit     is_mem;
    int     states[$];
    e.alu = 7; e.regwe = 0; e.pcwe = 0; e.pcsrc = 0; e.memwe = 0; e.ext = -1;
    is_mem = 0;
    states = '{0, 1};
    case (op)
      6'b000000: begin
        states.push_back(2); states.push_back(7); e.regwe = 1;
        case (fn)
          6'b100001: e.alu = 0;
          6'b100011: e.alu = 1;
          6'b100100: e.alu = 2;
          6'b100101: e.alu = 3;
          default:   e.alu = 4;
        endcase
      end
      6'b001001: begin states.push_back(3); states.push_back(8); e.alu = 0; e.ext = 1; e.regwe = 1; end
      6'b001101: begin states.push_back(3); states.push_back(8); e.alu = 3; e.ext = 0; e.regwe = 1; end
      6'b100011: begin
        states.push_back(4); states.push_back(5); states.push_back(9);
        e.alu = 0; e.ext = 1; e.regwe = 1; is_mem = 1;
      end
      6'b101011: begin states.push_back(4); states.push_back(6); e.alu = 0; e.ext = 1; e.memwe = 1; is_mem = 1; end
      6'b000100: begin states.push_back(10); e.alu = 1; e.pcwe = int'(z); e.pcsrc = 1; end
      default:   begin states.push_back(11); e.pcwe = 1; e.pcsrc = 2; end
    endcase
    e.trace = 32'hFFFFFF;
    foreach (states[i]) e.trace = push_st(e.trace, states[i]);
    nst   = states.size();
    e.lat = nst + fw + (is_mem ? mw : 0);
    p.op = op; p.fn = fn; p.z = z;
    prog_q.push_back(p);
    wait_q.push_back(fw);
    if (is_mem) wait_q.push_back(mw);
    exp_q.push_back(e);
  endtask

  task automatic finalize();
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL unexpected_retire: got trace 0x%0h, expected no instruction", rec_trace);
      return;
    end
    e = exp_q.pop_front();
    n_ret++;
    sum_lat += e.lat;
    chk("trace", rec_trace, e.trace);
    chk("latency", rec_len, e.lat);
    chk("alu_ctr", rec_alu, e.alu);
    chk("reg_we_cycles", rec_regwe, e.regwe);
    chk("pc_we_cycles", rec_pcwe, e.pcwe);
    if (e.pcwe > 0) chk("pc_src", rec_pcsrc, e.pcsrc);
    chk("mem_we_xfers", rec_memwe, e.memwe);
    if (e.ext >= 0) chk("ext_op", rec_ext, e.ext);
    chk("ctrl_rule_errors", rec_err, 0);
    chk("instret", instret, n_ret);
    chk("cycles", cycles, sum_lat);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    prog_q.delete(); wait_q.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic illegal_case(input logic [5:0] op, input logic [5:0] fn);
    instr_t p;
    int     en;
    apply_reset();
    p.op = op; p.fn = fn; p.z = 1'b0;
    prog_q.push_back(p);
    wait_q.push_back(0);
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      if (state == 4'd12) break;
    end
    chk("illegal_state", state, 12);
    chk("illegal_flag", illegal, 1);
    chk("illegal_timeout_flag", timeout, 0);
    chk("illegal_instret", instret, 0);
    chk("illegal_cycles", cycles, 2);
    en = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      if (reg_we || pc_we || ir_we || mem_req) en++;
    end
    chk("illegal_no_enables", en, 0);
  endtask

  initial begin
    fork
      // driver: IR load after fetch transfers, memory model with stall counts
      forever begin
        @(negedge clk);
        if (!reset) begin
          cur_wait = -1; load_ir = 0; mem_ready = 1'b0;
        end else begin
          if (load_ir) begin
            load_ir = 0;
            if (prog_q.size() > 0) begin
              ins = prog_q.pop_front();
              opcode = ins.op; funct = ins.fn; zf = ins.z;
            end
          end
          if (mem_req) begin
            if (cur_wait < 0 && wait_q.size() > 0) cur_wait = wait_q.pop_front();
            if (cur_wait < 0) mem_ready = 1'b0;
            else if (cur_wait > 0) begin mem_ready = 1'b0; cur_wait--; end
            else begin
              mem_ready = 1'b1; cur_wait = -1;
              if (!iord) load_ir = 1;
            end
          end else begin
            mem_ready = 1'($urandom_range(0, 1));
          end
        end
      end
      // monitor: builds one record per instruction, compares at the next FETCH
      forever begin
        @(negedge clk); #2;
        if (!mon_en || !reset) begin
          prev_st = 15; have_rec = 0;
        end else begin
          if (state == 4'd0 && prev_st != 0) begin
            if (have_rec) finalize();
            have_rec = 1;
            rec_trace = 32'hFFFFFF; rec_len = 0; rec_alu = 7; rec_ext = -1;
            rec_regwe = 0; rec_pcwe = 0; rec_pcsrc = 0; rec_memwe = 0; rec_err = 0;
          end
          if (have_rec) begin
            rec_len++;
            if ((rec_trace & 15) != int'(state)) rec_trace = push_st(rec_trace, int'(state));
            if (state == 2 || state == 3 || state == 4 || state == 10) rec_alu = int'(alu_ctr);
            if (state == 3 || state == 4) rec_ext = int'(ext_op);
            if (reg_we) rec_regwe++;
            if (state != 0 && pc_we) begin rec_pcwe++; rec_pcsrc = int'(pc_src); end
            if (mem_req && mem_we && mem_ready) rec_memwe++;
            if (mem_req && (iord != (state != 0))) rec_err++;
            if (state == 0 && (ir_we != mem_ready || pc_we != mem_ready ||
                               alu_src_b != 2'b01 || alu_src_a || pc_src != 2'b00)) rec_err++;
            if (state == 1 && (alu_src_b != 2'b11 || alu_src_a)) rec_err++;
            if (reg_we && (reg_dst != (state != 7) || mem_to_reg != (state == 9))) rec_err++;
          end
          prev_st = int'(state);
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    // ---- reset state
    #1 reset = 1'b0;
    #3;
    chk("rst_state", state, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir_we", ir_we, 0);
    chk("rst_alu_src_b", alu_src_b, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_instret", instret, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_timeout", timeout, 0);
    @(posedge clk); #2;
    chk("rst_hold_mem_req", mem_req, 0);

    // ---- directed stream (no stalls) then beq not-taken, then random stream
    issue(6'b000000, 6'b100001, 1'b0, 0, 0);
    issue(6'b001101, 6'b000000, 1'b0, 0, 0);
    issue(6'b100011, 6'b000000, 1'b0, 0, 0);
    issue(6'b101011, 6'b000000, 1'b0, 0, 0);
    issue(6'b000100, 6'b000000, 1'b1, 0, 0);
    issue(6'b000010, 6'b000000, 1'b0, 0, 0);
    issue(6'b000100, 6'b000000, 1'b0, 0, 0);
    issue(6'b100011, 6'b000000, 1'b0, 0, 3);
    for (int i = 0; i < 40; i++) begin
      int          k;
      logic [5:0]  op, fn;
      logic [5:0]  rfn [5];
      rfn = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010};
      k  = $urandom_range(0, 10);
      fn = 6'($urandom);
      case (k)
        0, 1, 2, 3, 4: begin op = 6'b000000; fn = rfn[k]; end
        5:       op = 6'b001001;
        6:       op = 6'b001101;
        7:       op = 6'b100011;
        8:       op = 6'b101011;
        9:       op = 6'b000100;
        default: op = 6'b000010;
      endcase
      issue(op, fn, 1'($urandom), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
    end
    mon_en = 1;
    @(posedge clk); #2 reset = 1'b1;
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    chk("stream_outstanding", exp_q.size(), 0);
    @(negedge clk); #3;
    mon_en = 0;

    // ---- fetch timeout: ready held low
    apply_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clk); #2;
    chk("tmo_state_before", state, 0);
    chk("tmo_flag_before", timeout, 0);
    @(posedge clk); #2;
    chk("tmo_state", state, 12);
    chk("tmo_flag", timeout, 1);
    chk("tmo_cycles", cycles, 4);
    chk("tmo_illegal", illegal, 0);
    repeat (3) @(posedge clk); #2;
    chk("tmo_cycles_frozen", cycles, 4);
    chk("tmo_halt_mem_req", mem_req, 0);

    // ---- illegal opcode and illegal R funct
    illegal_case(6'b111111, 6'b100001);
    illegal_case(6'b000000, 6'b000000);

    // ---- reset pulse while stalled in MEM_WR
    apply_reset();
    begin
      instr_t p;
      p.op = 6'b101011; p.fn = 6'd0; p.z = 1'b0;
      prog_q.push_back(p);
      wait_q.push_back(0);
      wait_q.push_back(3);
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (state == 4'd6) break;
    end
    chk("memwr_reached", state, 6);
    chk("memwr_cycles", cycles, 3);
    @(negedge clk); #2;
    chk("memwr_req_before", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("memwr_rst_mem_req", mem_req, 0);
    chk("memwr_rst_mem_we", mem_we, 0);
    chk("memwr_rst_state", state, 0);
    chk("memwr_rst_cycles", cycles, 0);
    chk("memwr_rst_instret", instret, 0);
    chk("memwr_rst_flags", {illegal, timeout}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
